// File: rtl/shift_add_mult8.sv
// shift_add_mult8: sequential 8x8 unsigned shift-and-add multiplier built on Ripple_Add
module Ripple_Add (
  output logic [7:0] S,
  output logic       Cout,
  input  logic [7:0] A,
  input  logic [7:0] B
);
  logic [8:0] c;
  assign c[0] = 1'b0;
  assign Cout = c[8];
  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign S[i]   = A[i] ^ B[i] ^ c[i];
    assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
  end
endmodule

module shift_add_mult8 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        busy,
  output logic        done,
  output logic [15:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t     state;
  logic [7:0] m, q, acc, sum, acc_n;
  logic       c, cout, c_n;
  logic [3:0] cnt;
  Ripple_Add u_add (.S(sum), .Cout(cout), .A(acc), .B(m));
  // Conditional add: C is always 0 between iterations, so it stands in for the no-add carry
  always_comb begin
    c_n   = q[0] ? cout : c;
    acc_n = q[0] ? sum : acc;
  end
  // Control FSM and datapath; a 17-bit right shift of {C,ACC,Q} each RUN cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= 16'h0000;
      m       <= 8'h00;
      q       <= 8'h00;
      acc     <= 8'h00;
      c       <= 1'b0;
      cnt     <= 4'd0;
    end else begin
      case (state)
        RUN: begin
          c   <= 1'b0;
          acc <= {c_n, acc_n[7:1]};
          q   <= {acc_n[0], q[7:1]};
          cnt <= cnt + 4'd1;
          if (cnt == 4'd7) begin
            product <= {c_n, acc_n, q[7:1]};
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            m     <= a;
            q     <= b;
            acc   <= 8'h00;
            c     <= 1'b0;
            cnt   <= 4'd0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
